mult4_hex_display: RTL and testbench

- Registered 4x4 unsigned multiplier with a built-in seven-segment hex decoder.
- Captures two 4-bit factors and produces the 8-bit product.
- Drives two seven-segment digit patterns (high and low product nibble).
- Sits between the operand-capture/input logic and the display multiplexing logic in the top-level ASIC multiplier demo.

---
 rtl/mult4_hex_display_pkg.sv | 33 +++
 rtl/mult4_hex_display_if.sv | 22 ++
 rtl/mult4_hex_display_hex_seg7_decoder.sv | 16 +
 rtl/mult4_hex_display.sv | 60 ++++++
 tb/tb_mult4_hex_display.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/mult4_hex_display_pkg.sv
// Shared widths, segment bit indices and the hex-to-seven-segment table.
package mult4_hex_display_pkg;

  localparam int unsigned FACTOR_W = 4;
  localparam int unsigned PROD_W   = 8;
  localparam int unsigned NIBBLE_W = 4;
  localparam int unsigned SEG_W    = 7;

  // Segment bit positions inside a pattern
  localparam int unsigned SEG_A = 0;
  localparam int unsigned SEG_B = 1;
  localparam int unsigned SEG_C = 2;
  localparam int unsigned SEG_D = 3;
  localparam int unsigned SEG_E = 4;
  localparam int unsigned SEG_F = 5;
  localparam int unsigned SEG_G = 6;

  // Active-high patterns, index = hex digit (leftmost entry is digit F)
  localparam logic [15:0][SEG_W-1:0] HEX_SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  // Pattern for one digit with optional inversion for common-anode parts
  function automatic logic [SEG_W-1:0] hex_to_seg(input logic [NIBBLE_W-1:0] nibble,
                                                   input logic active_low);
    logic [SEG_W-1:0] seg;
    seg = HEX_SEG_TABLE[nibble];
    if (active_low) seg = ~seg;
    return seg;
  endfunction

endpackage

// File: rtl/mult4_hex_display_if.sv
// Operand load and product/segment result bundle.
interface mult4_hex_display_if;
  import mult4_hex_display_pkg::*;

  logic [FACTOR_W-1:0] i_factor_a;
  logic [FACTOR_W-1:0] i_factor_b;
  logic                i_valid;
  logic [PROD_W-1:0]   o_mult;
  logic [SEG_W-1:0]    o_seg_hi;
  logic [SEG_W-1:0]    o_seg_lo;
  logic                o_valid;

  modport master (
    output i_factor_a, i_factor_b, i_valid,
    input  o_mult, o_seg_hi, o_seg_lo, o_valid
  );

  modport slave (
    input  i_factor_a, i_factor_b, i_valid,
    output o_mult, o_seg_hi, o_seg_lo, o_valid
  );
endinterface

// File: rtl/mult4_hex_display_hex_seg7_decoder.sv
// Combinational 4-bit hex digit to 7-segment pattern (bit0=a .. bit6=g).
module hex_seg7_decoder
  import mult4_hex_display_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic [NIBBLE_W-1:0] i_nibble,
  output logic [SEG_W-1:0]    o_seg_c
);

  // Table lookup covers all 16 codes, inversion applied for common-anode
  always_comb begin
    o_seg_c = hex_to_seg(i_nibble, SEG_ACTIVE_LOW);
  end

endmodule

// File: rtl/mult4_hex_display.sv
// Registered 4x4 unsigned multiplier with two hex seven-segment digit outputs.
module mult4_hex_display
  import mult4_hex_display_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  mult4_hex_display_if.slave    bus
);

  localparam logic [SEG_W-1:0] SEG_RST = hex_to_seg(NIBBLE_W'(0), SEG_ACTIVE_LOW);

  logic [PROD_W-1:0] mult_d,   mult_q;
  logic [SEG_W-1:0]  seg_hi_d, seg_hi_q;
  logic [SEG_W-1:0]  seg_lo_d, seg_lo_q;
  logic              valid_d,  valid_q;

  // Next product: load on strobe, otherwise hold; valid pulses once per load
  always_comb begin
    mult_d  = mult_q;
    valid_d = 1'b0;
    if (bus.i_valid) begin
      mult_d  = PROD_W'(bus.i_factor_a) * PROD_W'(bus.i_factor_b);
      valid_d = 1'b1;
    end
  end

  // Decode the next product so segments update in the same cycle as o_mult
  hex_seg7_decoder #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_dec_hi (
    .i_nibble (mult_d[PROD_W-1:NIBBLE_W]),
    .o_seg_c  (seg_hi_d)
  );

  hex_seg7_decoder #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_dec_lo (
    .i_nibble (mult_d[NIBBLE_W-1:0]),
    .o_seg_c  (seg_lo_d)
  );

  // Output registers with asynchronous reset to a displayed zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mult_q   <= '0;
      seg_hi_q <= SEG_RST;
      seg_lo_q <= SEG_RST;
      valid_q  <= 1'b0;
    end else begin
      mult_q   <= mult_d;
      seg_hi_q <= seg_hi_d;
      seg_lo_q <= seg_lo_d;
      valid_q  <= valid_d;
    end
  end

  assign bus.o_mult   = mult_q;
  assign bus.o_seg_hi = seg_hi_q;
  assign bus.o_seg_lo = seg_lo_q;
  assign bus.o_valid  = valid_q;

endmodule

// File: tb/tb_mult4_hex_display.sv
// Directed bench for mult4_hex_display: active-high and active-low instances.
module tb_mult4_hex_display;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  // Hand-written active-high digit patterns, index = hex digit
  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  mult4_hex_display_if bus ();
  mult4_hex_display_if bus_al ();

  mult4_hex_display #(.SEG_ACTIVE_LOW(1'b0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  mult4_hex_display #(.SEG_ACTIVE_LOW(1'b1)) dut_al (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_al)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive both instances, wait one rising edge, land 1 time unit after it
  task automatic cycle(input logic [3:0] a, input logic [3:0] b, input logic v);
    bus.i_factor_a    = a;
    bus.i_factor_b    = b;
    bus.i_valid       = v;
    bus_al.i_factor_a = a;
    bus_al.i_factor_b = b;
    bus_al.i_valid    = v;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++;
    if (bus.o_mult !== 8'h00 || bus.o_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_init: mult=%h valid=%b, want 00/0", bus.o_mult, bus.o_valid);
    end
    checks++;
    if (bus.o_seg_hi !== 7'h3F || bus.o_seg_lo !== 7'h3F ||
        bus_al.o_seg_hi !== 7'h40 || bus_al.o_seg_lo !== 7'h40) begin
      errors++;
      $display("FAIL reset_init_seg: hi=%h lo=%h al_hi=%h al_lo=%h, want 3F/3F/40/40",
               bus.o_seg_hi, bus.o_seg_lo, bus_al.o_seg_hi, bus_al.o_seg_lo);
    end
    reset = 1'b0;
    cycle(4'd7, 4'd7, 1'b1);
    checks++;
    if (bus.o_mult !== 8'h31 || bus.o_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_preload: mult=%h valid=%b, want 31/1", bus.o_mult, bus.o_valid);
    end
    // Assert reset away from any clock edge; outputs must clear at once
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.o_mult !== 8'h00 || bus.o_valid !== 1'b0 ||
        bus.o_seg_hi !== 7'h3F || bus.o_seg_lo !== 7'h3F) begin
      errors++;
      $display("FAIL reset_async: mult=%h valid=%b hi=%h lo=%h, want 00/0/3F/3F",
               bus.o_mult, bus.o_valid, bus.o_seg_hi, bus.o_seg_lo);
    end
    checks++;
    if (bus_al.o_seg_hi !== 7'h40 || bus_al.o_seg_lo !== 7'h40 || bus_al.o_mult !== 8'h00) begin
      errors++;
      $display("FAIL reset_async_al: mult=%h hi=%h lo=%h, want 00/40/40",
               bus_al.o_mult, bus_al.o_seg_hi, bus_al.o_seg_lo);
    end
    cycle(4'd0, 4'd0, 1'b0);
    reset = 1'b0;
  endtask

  task automatic test_basic();
    cycle(4'd7, 4'd7, 1'b1);
    checks++;
    if (bus.o_mult !== 8'h31 || bus.o_seg_hi !== 7'h4F || bus.o_seg_lo !== 7'h06 ||
        bus.o_valid !== 1'b1) begin
      errors++;
      $display("FAIL basic_7x7: mult=%h hi=%h lo=%h valid=%b, want 31/4F/06/1",
               bus.o_mult, bus.o_seg_hi, bus.o_seg_lo, bus.o_valid);
    end
    cycle(4'd7, 4'd7, 1'b0);
    checks++;
    if (bus.o_mult !== 8'h31 || bus.o_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_pulse: mult=%h valid=%b, want 31/0", bus.o_mult, bus.o_valid);
    end
  endtask

  task automatic test_max();
    cycle(4'd15, 4'd15, 1'b1);
    checks++;
    if (bus.o_mult !== 8'hE1 || bus.o_seg_hi !== 7'h79 || bus.o_seg_lo !== 7'h06) begin
      errors++;
      $display("FAIL max_15x15: mult=%h hi=%h lo=%h, want E1/79/06",
               bus.o_mult, bus.o_seg_hi, bus.o_seg_lo);
    end
    cycle(4'd0, 4'd9, 1'b1);
    checks++;
    if (bus.o_mult !== 8'h00 || bus.o_seg_hi !== 7'h3F || bus.o_seg_lo !== 7'h3F ||
        bus.o_valid !== 1'b1) begin
      errors++;
      $display("FAIL zero_0x9: mult=%h hi=%h lo=%h valid=%b, want 00/3F/3F/1",
               bus.o_mult, bus.o_seg_hi, bus.o_seg_lo, bus.o_valid);
    end
  endtask

  task automatic test_hold();
    cycle(4'd3, 4'd5, 1'b1);
    checks++;
    if (bus.o_mult !== 8'h0F || bus.o_seg_hi !== 7'h3F || bus.o_seg_lo !== 7'h71) begin
      errors++;
      $display("FAIL hold_load: mult=%h hi=%h lo=%h, want 0F/3F/71",
               bus.o_mult, bus.o_seg_hi, bus.o_seg_lo);
    end
    for (int i = 0; i < 10; i++) begin
      cycle(4'd6, 4'd6, 1'b0);
      checks++;
      if (bus.o_mult !== 8'h0F || bus.o_seg_hi !== 7'h3F || bus.o_seg_lo !== 7'h71 ||
          bus.o_valid !== 1'b0) begin
        errors++;
        $display("FAIL hold_cycle%0d: mult=%h hi=%h lo=%h valid=%b, want 0F/3F/71/0",
                 i, bus.o_mult, bus.o_seg_hi, bus.o_seg_lo, bus.o_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_p;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        exp_p = 8'(a * b);
        cycle(4'(a), 4'(b), 1'b1);
        checks++;
        if (bus.o_mult !== exp_p || bus.o_valid !== 1'b1) begin
          errors++;
          $display("FAIL sweep_%0dx%0d: mult=%h valid=%b, want %h/1",
                   a, b, bus.o_mult, bus.o_valid, exp_p);
        end
        checks++;
        if (bus.o_seg_hi !== seg_tab[exp_p[7:4]] || bus.o_seg_lo !== seg_tab[exp_p[3:0]]) begin
          errors++;
          $display("FAIL sweep_seg_%0dx%0d: hi=%h lo=%h, want %h/%h", a, b,
                   bus.o_seg_hi, bus.o_seg_lo, seg_tab[exp_p[7:4]], seg_tab[exp_p[3:0]]);
        end
        checks++;
        if (bus_al.o_seg_hi !== ~seg_tab[exp_p[7:4]] || bus_al.o_seg_lo !== ~seg_tab[exp_p[3:0]]) begin
          errors++;
          $display("FAIL sweep_al_%0dx%0d: hi=%h lo=%h, want %h/%h", a, b,
                   bus_al.o_seg_hi, bus_al.o_seg_lo, ~seg_tab[exp_p[7:4]], ~seg_tab[exp_p[3:0]]);
        end
      end
    end
    cycle(4'd0, 4'd0, 1'b0);
  endtask

  task automatic test_active_low();
    cycle(4'd2, 4'd6, 1'b1);
    checks++;
    if (bus_al.o_mult !== 8'h0C || bus_al.o_seg_hi !== 7'h40 || bus_al.o_seg_lo !== 7'h46) begin
      errors++;
      $display("FAIL active_low_2x6: mult=%h hi=%h lo=%h, want 0C/40/46",
               bus_al.o_mult, bus_al.o_seg_hi, bus_al.o_seg_lo);
    end
  endtask

  task automatic test_reset_priority();
    reset = 1'b1;
    cycle(4'd15, 4'd15, 1'b1);
    checks++;
    if (bus.o_mult !== 8'h00 || bus.o_valid !== 1'b0 || bus.o_seg_lo !== 7'h3F) begin
      errors++;
      $display("FAIL reset_priority: mult=%h valid=%b lo=%h, want 00/0/3F",
               bus.o_mult, bus.o_valid, bus.o_seg_lo);
    end
    reset = 1'b0;
    cycle(4'd15, 4'd15, 1'b0);
    checks++;
    if (bus.o_mult !== 8'h00 || bus.o_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_idle: mult=%h valid=%b, want 00/0", bus.o_mult, bus.o_valid);
    end
    cycle(4'd1, 4'd1, 1'b1);
    checks++;
    if (bus.o_mult !== 8'h01 || bus.o_seg_hi !== 7'h3F || bus.o_seg_lo !== 7'h06 ||
        bus.o_valid !== 1'b1) begin
      errors++;
      $display("FAIL fresh_load: mult=%h hi=%h lo=%h valid=%b, want 01/3F/06/1",
               bus.o_mult, bus.o_seg_hi, bus.o_seg_lo, bus.o_valid);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.i_factor_a    = '0;
    bus.i_factor_b    = '0;
    bus.i_valid       = 1'b0;
    bus_al.i_factor_a = '0;
    bus_al.i_factor_b = '0;
    bus_al.i_valid    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_max();
    test_hold();
    test_back_to_back();
    test_active_low();
    test_reset_priority();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
